// File: rtl/iob_fp_mul_stream_pkg.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_stream_pkg
// Shared definitions for the FP multiplier streaming front-end:
//   - default operand width and result FIFO depth
//   - IEEE-754 single-precision special bit patterns (zero, infinity, quiet NaN)
//   - FIFO operation encoding used by the result FIFO bookkeeping
// -----------------------------------------------------------------------------
package iob_fp_mul_stream_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

    // Encoding matches {push, pop}, so a plain cast gives the operation.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/iob_fp_mul_stream_if.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_stream_if
// Operand-in / result-out stream bundle of the FP multiplier front-end.
//   in_valid, in_ready, op_a, op_b : operand pair stream into the block
//   out_valid, out_ready, out_data : result stream out of the block
// Modports:
//   master : the environment (produces operands, consumes results)
//   slave  : the front-end block
// -----------------------------------------------------------------------------
interface iob_fp_mul_stream_if
    import iob_fp_mul_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iob_fp_res_fifo.sv
// -----------------------------------------------------------------------------
// iob_fp_res_fifo
// Synchronous first-word-fall-through FIFO holding multiplier results.
// Ports:
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   push_i, data_i  : write data_i at the tail
//   pop_i           : drop the head (ignored when empty)
//   valid_o, data_o : head valid / head value (0 while empty)
//   count_o         : number of stored entries (0..DEPTH)
// Pointers wrap modulo DEPTH, which must be a power of two.
// -----------------------------------------------------------------------------
module iob_fp_res_fifo
    import iob_fp_mul_stream_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              do_pop;
    fifo_op_e          op;

    assign do_pop = pop_i & (count_q != '0);
    assign op     = fifo_op_e'({push_i, do_pop});

    // NOTE: the storage array has no reset; only pointers and count do, and
    // the head is masked while empty so stale contents never reach data_o.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a latch.
    always_comb begin
        count_d = count_q;
        case (op)
            FIFO_PUSH: count_d = count_q + CNT_W'(1);
            FIFO_POP:  count_d = count_q - CNT_W'(1);
            default:   count_d = count_q;
        endcase
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/iob_fp_mul_stream.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_stream
// Valid/ready front-end for the non-stallable pipelined FP multiplier.
// Accepts operand pairs, issues one-cycle start pulses with registered
// operands, and captures done/result pulses into a result FIFO.
// Admission is credit based: an op is accepted only while
// fifo_count + inflight < DEPTH, so every issued op has a FIFO slot.
// Ports:
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   strm (slave)             : operand stream in, result stream out
//   mul_start_o              : one-cycle start pulse to the multiplier
//   mul_op_a_o, mul_op_b_o   : registered operands, held until next accept
//   mul_done_i, mul_res_i    : multiplier completion and result
//   inflight_o               : ops issued and not yet returned
//   err_o                    : sticky, done seen with nothing in flight
// Optional (macro IOB_FP_MUL_STREAM_STATS_EN):
//   issued_cnt_o             : wrapping count of accepted pairs
//   stall_cnt_o              : saturating count of cycles valid but not ready
// -----------------------------------------------------------------------------
module iob_fp_mul_stream
    import iob_fp_mul_stream_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    iob_fp_mul_stream_if.slave  strm,
    output logic                mul_start_o,
    output logic [DATA_W-1:0]   mul_op_a_o,
    output logic [DATA_W-1:0]   mul_op_b_o,
    input  logic                mul_done_i,
    input  logic [DATA_W-1:0]   mul_res_i,
    output logic [CNT_W-1:0]    inflight_o,
    output logic                err_o
`ifdef IOB_FP_MUL_STREAM_STATS_EN
    ,
    output logic [31:0]         issued_cnt_o,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic              ready_en_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  inflight_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credits_used;
    logic              accept;
    logic              pop;
    logic              done_ok;
    logic              done_bad;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;

    // ready_en_q keeps in_ready low during reset and releases it one edge
    // after reset is removed; the credit term itself comes only from
    // registered counters and never looks at in_valid.
    assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign strm.in_ready = ready_en_q & (credits_used < CREDITS);

    assign accept   = strm.in_valid & strm.in_ready;
    assign pop      = fifo_valid & strm.out_ready;
    assign done_ok  = mul_done_i & (inflight_q != '0);
    assign done_bad = mul_done_i & (inflight_q == '0);

    // Accept and return in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, done_ok})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ready_en_q  <= 1'b0;
            mul_start_o <= 1'b0;
            mul_op_a_o  <= '0;
            mul_op_b_o  <= '0;
            inflight_q  <= '0;
            err_o       <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            mul_start_o <= accept;
            if (accept) begin
                mul_op_a_o <= strm.op_a;
                mul_op_b_o <= strm.op_b;
            end
            inflight_q <= inflight_d;
            // A result nobody asked for is dropped; the flag stays until reset.
            if (done_bad) err_o <= 1'b1;
        end
    end

    iob_fp_res_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_res_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push_i   (done_ok),
        .data_i   (mul_res_i),
        .pop_i    (pop),
        .valid_o  (fifo_valid),
        .data_o   (fifo_data),
        .count_o  (fifo_count)
    );

    assign strm.out_valid = fifo_valid;
    assign strm.out_data  = fifo_data;
    assign inflight_o     = inflight_q;

`ifdef IOB_FP_MUL_STREAM_STATS_EN
    logic stall;

    assign stall = strm.in_valid & ~strm.in_ready;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            issued_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (accept) issued_cnt_o <= issued_cnt_o + 32'd1;
            if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_fp_mul_stream.sv
// -----------------------------------------------------------------------------
// tb_iob_fp_mul_stream
// Bench for iob_fp_mul_stream with a fixed-latency multiplier model, a
// queue-based reference of the front-end and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_iob_fp_mul_stream;
    import iob_fp_mul_stream_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LAT    = 4;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    iob_fp_mul_stream_if #(.DATA_W(DATA_W)) strm ();

    logic              mul_start;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_done;
    logic [DATA_W-1:0] mul_res;
    logic [CNT_W-1:0]  inflight;
    logic              err;
    logic              spur_req;

    iob_fp_mul_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .strm        (strm),
        .mul_start_o (mul_start),
        .mul_op_a_o  (mul_a),
        .mul_op_b_o  (mul_b),
        .mul_done_i  (mul_done),
        .mul_res_i   (mul_res),
        .inflight_o  (inflight),
        .err_o       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Single-precision multiply of normal numbers, truncating; exact for the
    // small-integer operands this bench uses.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[22:0] != 0 || b[22:0] != 0) return FP32_QNAN;
            return {s, FP32_POS_INF[30:0]};
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, FP32_POS_ZERO[30:0]};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] int_to_fp(input int unsigned k);
        int          m;
        logic [31:0] man;
        if (k == 0) return FP32_POS_ZERO;
        m = 0;
        for (int i = 0; i < 32; i++) if (k[i]) m = i;
        man = k << (23 - m);
        return {1'b0, 8'(127 + m), man[22:0]};
    endfunction

    // ---------------- multiplier model: fixed latency, cannot stall --------
    initial begin : mult_model
        logic              pv [LAT];
        logic [31:0]       pd [LAT];
        logic              s, sp;
        logic [31:0]       a, b;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(negedge clk);
            s = mul_start; a = mul_a; b = mul_b; sp = spur_req;
            @(posedge clk);
            #1;
            for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
            pv[0] = s;
            pd[0] = fp_mul(a, b);
            mul_done = pv[LAT-1] | sp;
            mul_res  = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD_BEEF;
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] exp_q [$];   // FIFO contents in arrival order
    logic [31:0] ord_q [$];   // products of accepted pairs in issue order
    int          m_inflight;
    bit          m_err, m_en, m_start;
    logic [31:0] m_a, m_b;

    always @(negedge clk) begin : compare
        bit m_ready, acc, pop;
        if (!arst_n) begin
            check("rst_in_ready",  64'(strm.in_ready),  64'(0));
            check("rst_out_valid", 64'(strm.out_valid), 64'(0));
            check("rst_out_data",  64'(strm.out_data),  64'(0));
            check("rst_mul_start", 64'(mul_start),      64'(0));
            check("rst_mul_ops",   {mul_a, mul_b},      64'(0));
            check("rst_inflight",  64'(inflight),       64'(0));
            check("rst_err",       64'(err),            64'(0));
            exp_q.delete(); ord_q.delete();
            m_inflight = 0; m_err = 0; m_en = 0; m_start = 0; m_a = '0; m_b = '0;
        end else begin
            m_ready = m_en && (exp_q.size() + m_inflight < DEPTH);
            check("in_ready",  64'(strm.in_ready),  64'(m_ready));
            check("out_valid", 64'(strm.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("out_data", 64'(strm.out_data), 64'(exp_q[0]));
            check("inflight",  64'(inflight),  64'(m_inflight));
            check("err",       64'(err),       64'(m_err));
            check("mul_start", 64'(mul_start), 64'(m_start));
            check("mul_ops",   {mul_a, mul_b}, {m_a, m_b});

            acc = strm.in_valid && m_ready;
            pop = (exp_q.size() != 0) && strm.out_ready;
            if (pop) begin
                if (ord_q.size() != 0) check("issue_order", 64'(strm.out_data), 64'(ord_q.pop_front()));
                else check("extra_result", 64'(pop), 64'(0));
                void'(exp_q.pop_front());
            end
            if (mul_done) begin
                if (m_inflight == 0) m_err = 1;
                else begin
                    exp_q.push_back(mul_res);
                    m_inflight--;
                end
            end
            if (acc) begin
                m_inflight++;
                ord_q.push_back(fp_mul(strm.op_a, strm.op_b));
                m_a = strm.op_a;
                m_b = strm.op_b;
            end
            m_start = acc;
            m_en    = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        strm.op_a = int_to_fp($urandom_range(1, 1000)) | {$urandom_range(0, 1) == 1, 31'b0};
        strm.op_b = int_to_fp($urandom_range(1, 1000));
    endtask

    task automatic issue_n(input int n);
        int got;
        bit rdy;
        got = 0;
        strm.in_valid = 1'b1;
        rand_ops();
        for (int c = 0; c < 200 && got < n; c++) begin
            rdy = strm.in_ready;
            tick();
            if (rdy) begin got++; rand_ops(); end
        end
        strm.in_valid = 1'b0;
        check("issue_count", 64'(got), 64'(n));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && inflight != 0; c++) tick();
        check("wait_idle", 64'(inflight), 64'(0));
    endtask

    task automatic drain();
        strm.out_ready = 1'b1;
        for (int c = 0; c < 200 && (strm.out_valid || inflight != 0); c++) tick();
        strm.out_ready = 1'b0;
        check("drain_empty", {63'(inflight), strm.out_valid}, 64'(0));
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin : main
        int          n_acc, k;
        bit          rdy, acc, pop;
        logic [31:0] got_q [$];
        bit          all_ok;

        strm.in_valid  = 1'b0;
        strm.out_ready = 1'b0;
        strm.op_a      = '0;
        strm.op_b      = '0;
        spur_req       = 1'b0;

        #1 arst_n = 1'b0;
        repeat (3) tick();
        arst_n = 1'b1;
        tick();

        // Basic 2.0 * 3.0
        strm.in_valid = 1'b1;
        strm.op_a = 32'h4000_0000;
        strm.op_b = 32'h4040_0000;
        tick();
        strm.in_valid = 1'b0;
        check("basic_start_pulse", 64'(mul_start), 64'(1));
        tick();
        check("basic_start_single", 64'(mul_start), 64'(0));
        for (int c = 0; c < 20 && !strm.out_valid; c++) tick();
        check("basic_result", 64'(strm.out_data), 64'h40C0_0000);
        strm.out_ready = 1'b1;
        tick();
        strm.out_ready = 1'b0;
        check("basic_inflight_zero", 64'(inflight), 64'(0));

        // Full credit: exactly DEPTH accepts with no consumer
        n_acc = 0;
        strm.in_valid = 1'b1;
        rand_ops();
        for (int c = 0; c < 30; c++) begin
            rdy = strm.in_ready;
            tick();
            if (rdy) begin n_acc++; rand_ops(); end
        end
        strm.in_valid = 1'b0;
        check("full_accepts", 64'(n_acc), 64'(8));
        wait_idle();
        check("full_no_credit", 64'(strm.in_ready), 64'(0));
        strm.out_ready = 1'b1;
        tick();
        strm.out_ready = 1'b0;
        check("full_credit_back", 64'(strm.in_ready), 64'(1));
        drain();

        // Streaming k*1.0 * 2.0 with random backpressure
        k = 1;
        strm.in_valid = 1'b1;
        strm.op_a = int_to_fp(1);
        strm.op_b = 32'h4000_0000;
        for (int c = 0; c < 3000 && got_q.size() < 32; c++) begin
            strm.out_ready = ($urandom_range(0, 1) == 1);
            acc = strm.in_valid && strm.in_ready;
            pop = strm.out_valid && strm.out_ready;
            if (pop) got_q.push_back(strm.out_data);
            tick();
            if (acc) begin
                k++;
                if (k > 32) strm.in_valid = 1'b0;
                else strm.op_a = int_to_fp(k);
            end
        end
        strm.in_valid  = 1'b0;
        strm.out_ready = 1'b0;
        check("stream_count", 64'(got_q.size()), 64'(32));
        if (got_q.size() == 32) begin
            check("stream_first", 64'(got_q[0]),  64'h4000_0000);
            check("stream_last",  64'(got_q[31]), 64'h4280_0000);
            all_ok = 1;
            for (int i = 0; i < 32; i++) if (got_q[i] !== int_to_fp(2 * (i + 1))) all_ok = 0;
            check("stream_values", 64'(all_ok), 64'(1));
        end
        check("stream_no_err", 64'(err), 64'(0));
        drain();

        // Accept, done and pop in one cycle with 6 queued and 1 in flight
        issue_n(6);
        wait_idle();
        issue_n(1);
        for (int c = 0; c < 20 && !mul_done; c++) tick();
        check("simul_done_seen", 64'(mul_done), 64'(1));
        strm.in_valid  = 1'b1;
        rand_ops();
        strm.out_ready = 1'b1;
        tick();
        strm.in_valid  = 1'b0;
        strm.out_ready = 1'b0;
        check("simul_inflight", 64'(inflight), 64'(1));
        check("simul_in_ready", 64'(strm.in_ready), 64'(1));
        drain();

        // Spurious done with nothing in flight
        check("spur_err_before", 64'(err), 64'(0));
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        repeat (3) tick();
        check("spur_err_set", 64'(err), 64'(1));
        check("spur_fifo_empty", 64'(strm.out_valid), 64'(0));
        repeat (3) tick();
        check("spur_err_sticky", 64'(err), 64'(1));

        // Reset with 2 results queued and 3 ops in flight
        issue_n(2);
        wait_idle();
        issue_n(3);
        check("rmid_inflight", 64'(inflight), 64'(3));
        arst_n = 1'b0;
        #1;
        check("rmid_outputs_zero",
              {28'(0), strm.in_ready, strm.out_valid, mul_start, err, 32'(inflight)}, 64'(0));
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        check("rmid_in_ready", 64'(strm.in_ready), 64'(1));
        check("rmid_late_done_err", 64'(err), 64'(1));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
